// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared FSM state type and requester indices for the DM port arbiter
package dm_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} dm_arb_state_e;
    localparam int REQ_CPU = 0;
    localparam int REQ_BUS = 1;
endpackage

// File: rtl/dm_arb_rr2.sv
// dm_arb_rr2: two-way round-robin pick, rr_ptr selects the winner under contention
module dm_arb_rr2 (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic [1:0] gnt
);
    assign gnt[0] = valid[0] & (~valid[1] | ~rr_ptr);
    assign gnt[1] = valid[1] & (~valid[0] | rr_ptr);
endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single-port DM between CPU and bus requesters with lock and read routing
import dm_arb_pkg::*;
module dm_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    input  logic [DATA_W-1:0] DM_out,
    output logic              DM_enable,
    output logic              DM_write,
    output logic [ADDR_W-1:0] DM_address,
    output logic [DATA_W-1:0] DM_in
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    dm_arb_state_e state, state_nx;
    logic             rr_ptr, rr_ptr_nx;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nx;
    logic             rsp_pend, rsp_id;
    logic [1:0]       valid, rr_gnt, gnt;
    logic             acc, acc_id, acc_write, acc_lock, timeout;
    assign valid = {req1_valid, req0_valid};
    dm_arb_rr2 u_rr (.valid(valid), .rr_ptr(rr_ptr), .gnt(rr_gnt));
    // grants are forced low while reset is asserted so every output reads 0
    always_comb gnt = !rst ? 2'b00 : state == OWN0 ? {1'b0, valid[REQ_CPU]} :
                      state == OWN1 ? {valid[REQ_BUS], 1'b0} : rr_gnt;
    assign req0_ready  = gnt[REQ_CPU];
    assign req1_ready  = gnt[REQ_BUS];
    assign acc         = |gnt;
    assign acc_id      = gnt[REQ_BUS];
    assign acc_write   = acc_id ? req1_write : req0_write;
    assign acc_lock    = acc_id ? req1_lock : req0_lock;
    assign timeout     = lock_cnt == CNT_W'(MAX_LOCK);
    assign DM_enable   = acc;
    assign DM_write    = acc & acc_write;
    assign DM_address  = !acc ? '0 : acc_id ? req1_addr : req0_addr;
    assign DM_in       = !(acc & acc_write) ? '0 : acc_id ? req1_wdata : req0_wdata;
    assign req0_rvalid = rsp_pend & ~rsp_id;
    assign req1_rvalid = rsp_pend & rsp_id;
    assign req0_rdata  = req0_rvalid ? DM_out : '0;
    assign req1_rdata  = req1_rvalid ? DM_out : '0;
    always_comb begin
        state_nx    = state;
        rr_ptr_nx   = acc ? ~acc_id : rr_ptr;
        lock_cnt_nx = lock_cnt;
        if (state == IDLE) begin
            if (acc & acc_lock) begin
                state_nx    = acc_id ? OWN1 : OWN0;
                lock_cnt_nx = CNT_W'(1);
            end
        end else if (timeout) begin
            state_nx    = IDLE;
            lock_cnt_nx = '0;
            rr_ptr_nx   = state == OWN0;
        end else if (acc & ~acc_lock) begin
            state_nx    = IDLE;
            lock_cnt_nx = '0;
        end else begin
            lock_cnt_nx = lock_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            lock_cnt <= '0;
            rsp_pend <= 1'b0;
            rsp_id   <= 1'b0;
        end else begin
            state    <= state_nx;
            rr_ptr   <= rr_ptr_nx;
            lock_cnt <= lock_cnt_nx;
            rsp_pend <= acc & ~acc_write;
            rsp_id   <= acc_id;
        end
    end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed scenarios plus random traffic checked against an ownership-level model
module tb_dm_port_arbiter;
    localparam int MAXL = 16;
    logic        clk = 0, rst = 0;
    logic        v[2], w[2], l[2];
    logic [31:0] a[2], d[2];
    logic [31:0] dm_out;
    logic        req0_ready, req1_ready, req0_rvalid, req1_rvalid;
    logic [31:0] req0_rdata, req1_rdata;
    logic        DM_enable, DM_write;
    logic [31:0] DM_address, DM_in;
    int          n_chk = 0, n_pass = 0;
    int          owner, held, fav, pend, last_g;

    dm_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_write(w[0]), .req0_lock(l[0]), .req0_addr(a[0]), .req0_wdata(d[0]),
        .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(v[1]), .req1_write(w[1]), .req1_lock(l[1]), .req1_addr(a[1]), .req1_wdata(d[1]),
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .DM_out(dm_out), .DM_enable(DM_enable), .DM_write(DM_write),
        .DM_address(DM_address), .DM_in(DM_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input int n, input logic vv, input logic ww, input logic ll,
                         input logic [31:0] aa, input logic [31:0] dd);
        v[n] = vv; w[n] = ww; l[n] = ll; a[n] = aa; d[n] = dd;
    endtask

    function automatic int exp_grant();
        if (owner >= 0) return v[owner] ? owner : -1;
        if (v[0] && v[1]) return fav;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    // called at a negedge with inputs set; checks, advances the model, returns at next negedge
    task automatic step();
        int g;
        #1;
        g = exp_grant();
        chk("ready0", req0_ready, g == 0);
        chk("ready1", req1_ready, g == 1);
        chk("dm_enable", DM_enable, g >= 0);
        chk("dm_write", DM_write, g >= 0 && w[g]);
        chk("dm_address", DM_address, g >= 0 ? a[g] : 32'h0);
        chk("dm_in", DM_in, (g >= 0 && w[g]) ? d[g] : 32'h0);
        chk("rvalid0", req0_rvalid, pend == 0);
        chk("rvalid1", req1_rvalid, pend == 1);
        chk("rdata0", req0_rdata, pend == 0 ? dm_out : 32'h0);
        chk("rdata1", req1_rdata, pend == 1 ? dm_out : 32'h0);
        last_g = g;
        pend = (g >= 0 && !w[g]) ? g : -1;
        if (g >= 0) fav = 1 - g;
        if (owner >= 0) begin
            if (held == MAXL) begin
                fav = 1 - owner;
                owner = -1;
            end else if (g >= 0 && !l[g]) owner = -1;
            else held++;
        end else if (g >= 0 && l[g]) begin
            owner = g;
            held = 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 0;
        drive(0, 1, 1, 1, 32'h1234, 32'h5678);
        drive(1, 1, 0, 1, 32'h9abc, 32'hdef0);
        dm_out = 32'hffff_ffff;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_dm_enable", DM_enable, 0);
        chk("rst_dm_write", DM_write, 0);
        chk("rst_dm_address", DM_address, 0);
        chk("rst_dm_in", DM_in, 0);
        chk("rst_rvalid0", req0_rvalid, 0);
        chk("rst_rvalid1", req1_rvalid, 0);
        chk("rst_rdata0", req0_rdata, 0);
        chk("rst_rdata1", req1_rdata, 0);
        @(negedge clk);
        rst = 1;
        owner = -1; held = 0; fav = 0; pend = -1;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        dm_out = 0;
    endtask

    initial begin
        int k;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        dm_out = 0;
        owner = -1; held = 0; fav = 0; pend = -1; last_g = -1;
        @(negedge clk);
        do_reset();
        // single read from req0
        drive(0, 1, 0, 0, 32'h100, 0);
        step();
        chk("t1_grant", last_g, 0);
        drive(0, 0, 0, 0, 0, 0);
        dm_out = 32'hdead_beef;
        #1 chk("t1_rdata0", req0_rdata, 32'hdead_beef);
        step();
        // alternating writes from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0, 32'h10 + i, 32'hA0 + i);
            drive(1, 1, 1, 0, 32'h20 + i, 32'hB0 + i);
            step();
            chk("t2_grant", last_g, i % 2);
        end
        // req1 locked sequence while req0 waits
        drive(1, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0, 32'h30, 32'h1);
            drive(1, 1, 1, i < 2, 32'h40 + i, 32'h2);
            step();
            chk("t3_grant", last_g, i < 3 ? 1 : 0);
        end
        // lock timeout
        do_reset();
        k = -1;
        for (int i = 0; i < 40 && k < 0; i++) begin
            drive(0, 1, 1, 1, 32'h50, i);
            drive(1, 1, 1, 0, 32'h60, i);
            step();
            if (last_g == 1) k = i;
        end
        chk("t4_timeout_cycle", k, 17);
        // back-to-back reads to different requesters
        drive(0, 1, 0, 0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 32'h4, 0);
        dm_out = 32'ha0a0;
        #1 chk("t5_rdata0", req0_rdata, 32'ha0a0);
        step();
        drive(1, 0, 0, 0, 0, 0);
        dm_out = 32'hb1b1;
        #1 chk("t5_rdata1", req1_rdata, 32'hb1b1);
        chk("t5_rvalid0", req0_rvalid, 0);
        step();
        // reset while a read response is pending
        drive(1, 1, 0, 0, 32'h8, 0);
        step();
        do_reset();
        drive(0, 1, 0, 0, 32'hc, 0);
        drive(1, 1, 0, 0, 32'hd, 0);
        step();
        chk("t6_first_grant", last_g, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 2; n++)
                drive(n, $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                      $urandom, $urandom);
            dm_out = $urandom;
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
